hps_frame_scheduler: RTL and testbench

- Sits between the FFT magnitude stream and harmonic_product_spectrum (HPS), and sequences HPS one spectrum frame at a time.
- Gates whole 1024-bin frames into HPS only when HPS is free; drops and counts frames that arrive while it is busy.
- Tracks the argmax of the 32 HPS product beats and pairs it with the HPS max to emit a {bin, magnitude} pitch result.
- Recovers HPS via a reset pulse on short frames or a result timeout.

---
 rtl/hps_sched_pkg.sv | 21 ++
 rtl/hps_argmax.sv | 43 ++++
 rtl/hps_frame_scheduler.sv | 159 +++++++++++++++
 tb/tb_hps_frame_scheduler.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hps_sched_pkg.sv
// Shared types and constants for the HPS frame scheduler.
package hps_sched_pkg;
  localparam int HPS_NUM_PROD  = 32;
  localparam int HPS_FIRST_BIN = 2;
  localparam int HPS_FRAME_LEN = 1024;
  localparam int HPS_TIMEOUT   = 4096;
  localparam int HPS_PW        = 48;
  localparam int HPS_SW        = 24;

  typedef enum logic [1:0] {IDLE, FORWARD, WAIT, REPORT} state_e;

  typedef struct packed {
    logic [5:0]        bin;
    logic [HPS_PW-1:0] mag;
    logic              match;
  } hps_result_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
endpackage

// File: rtl/hps_argmax.sv
// Running argmax over the product beats of one HPS frame; ties keep the earliest beat.
module hps_argmax
  import hps_sched_pkg::*;
#(
  parameter int NUM_PROD = HPS_NUM_PROD,
  parameter int PW       = HPS_PW,
  localparam int IW      = $clog2(NUM_PROD),
  localparam int CW      = IW + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clear_i,
  input  logic          en_i,
  input  logic          p_valid_i,
  input  logic [PW-1:0] p_data_i,
  output logic [PW-1:0] best_o,
  output logic [IW-1:0] best_idx_o,
  output logic [CW-1:0] p_cnt_o
);
  localparam logic [CW-1:0] NP = CW'(NUM_PROD);

  logic [PW-1:0] best_q;
  logic [IW-1:0] idx_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!reset_n || clear_i) begin
      best_q <= '0;
      idx_q  <= '0;
      cnt_q  <= '0;
    end else if (en_i && p_valid_i && cnt_q < NP) begin
      if (p_data_i > best_q) begin
        best_q <= p_data_i;
        idx_q  <= cnt_q[IW-1:0];
      end
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign best_o     = best_q;
  assign best_idx_o = idx_q;
  assign p_cnt_o    = cnt_q;
endmodule

// File: rtl/hps_frame_scheduler.sv
// Gates whole spectrum frames into HPS, tracks the product argmax and emits one
// {bin, magnitude} pitch result per frame; recovers HPS on short frames or timeout.
module hps_frame_scheduler
  import hps_sched_pkg::*;
#(
  parameter int FRAME_LEN      = HPS_FRAME_LEN,
  parameter int NUM_PROD       = HPS_NUM_PROD,
  parameter int FIRST_BIN      = HPS_FIRST_BIN,
  parameter int TIMEOUT_CYCLES = HPS_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [HPS_SW-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              s_last,
  output logic [HPS_SW-1:0] h_data,
  output logic              h_valid,
  output logic              h_rst,
  input  logic [HPS_PW-1:0] p_data,
  input  logic              p_valid,
  output logic              p_ready,
  input  logic [HPS_PW-1:0] m_data,
  input  logic              m_valid,
  output logic              m_ready,
  output logic [5:0]        r_bin,
  output logic [HPS_PW-1:0] r_mag,
  output logic              r_match,
  output logic              r_valid,
  input  logic              r_ready,
  output logic [15:0]       frames_dropped,
  output logic              err_short,
  output logic              err_timeout
);
  localparam int IW = $clog2(NUM_PROD);
  localparam int CW = IW + 1;
  localparam int BW = $clog2(FRAME_LEN);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] NP_FULL   = CW'(NUM_PROD);
  localparam logic [CW-1:0] NP_LAST   = CW'(NUM_PROD - 1);
  localparam logic [BW-1:0] BEAT_LAST = BW'(FRAME_LEN - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [5:0]    FB        = 6'(FIRST_BIN);

  state_e              state_q;
  logic                in_frame_q;
  logic [BW-1:0]       beat_cnt_q;
  logic [TW-1:0]       tmo_q;
  logic                got_max_q;
  logic [HPS_PW-1:0]   m_cap_q;
  logic [15:0]         drop_q;
  logic                err_short_q, err_tmo_q, hrst_q;

  logic [HPS_PW-1:0]   best;
  logic [IW-1:0]       best_idx;
  logic [CW-1:0]       p_cnt;
  logic                start, collect, done_now, drop;
  hps_result_t         res;

  assign start    = (state_q == IDLE) && s_valid && !in_frame_q && !s_last;
  assign collect  = (state_q == FORWARD) || (state_q == WAIT);
  // The max or last product arriving this cycle already counts toward completion.
  assign done_now = (got_max_q || m_valid) &&
                    ((p_cnt == NP_FULL) || (p_valid && p_cnt == NP_LAST));
  assign drop     = s_valid && s_last &&
                    ((state_q == WAIT) || (state_q == REPORT) ||
                     ((state_q == IDLE) && in_frame_q));

  hps_argmax #(.NUM_PROD(NUM_PROD), .PW(HPS_PW)) u_argmax (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear_i   (start),
    .en_i      (collect),
    .p_valid_i (p_valid),
    .p_data_i  (p_data),
    .best_o    (best),
    .best_idx_o(best_idx),
    .p_cnt_o   (p_cnt)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      // Arm only after a frame boundary so a frame cut by reset is never forwarded.
      in_frame_q  <= 1'b1;
      beat_cnt_q  <= '0;
      tmo_q       <= '0;
      got_max_q   <= 1'b0;
      m_cap_q     <= '0;
      drop_q      <= '0;
      err_short_q <= 1'b0;
      err_tmo_q   <= 1'b0;
      hrst_q      <= 1'b0;
    end else begin
      err_short_q <= 1'b0;
      err_tmo_q   <= 1'b0;
      hrst_q      <= 1'b0;
      if (s_valid) in_frame_q <= !s_last;
      if (drop)    drop_q <= sat_inc16(drop_q);
      if (m_valid && collect) begin
        m_cap_q   <= m_data;
        got_max_q <= 1'b1;
      end
      case (state_q)
        IDLE: if (start) begin
          beat_cnt_q <= BW'(1);
          got_max_q  <= 1'b0;
          state_q    <= FORWARD;
        end
        FORWARD: if (s_valid) begin
          beat_cnt_q <= beat_cnt_q + 1'b1;
          if (beat_cnt_q == BEAT_LAST) begin
            tmo_q   <= '0;
            state_q <= WAIT;
          end else if (s_last) begin
            err_short_q <= 1'b1;
            hrst_q      <= 1'b1;
            state_q     <= IDLE;
          end
        end
        WAIT: begin
          tmo_q <= tmo_q + 1'b1;
          if (done_now) begin
            state_q <= REPORT;
          end else if (tmo_q == TMO_LAST) begin
            err_tmo_q <= 1'b1;
            hrst_q    <= 1'b1;
            state_q   <= IDLE;
          end
        end
        REPORT: if (r_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    res = '0;
    if (state_q == REPORT) begin
      res.bin   = 6'(best_idx) + FB;
      res.mag   = best;
      res.match = (best == m_cap_q);
    end
  end

  assign s_ready        = 1'b1;
  assign p_ready        = reset_n;
  assign h_data         = s_data;
  assign h_valid        = reset_n && s_valid && ((state_q == FORWARD) || start);
  assign h_rst          = !reset_n || hrst_q;
  assign m_ready        = reset_n && collect;
  assign r_valid        = (state_q == REPORT);
  assign r_bin          = res.bin;
  assign r_mag          = res.mag;
  assign r_match        = res.match;
  assign frames_dropped = drop_q;
  assign err_short      = err_short_q;
  assign err_timeout    = err_tmo_q;
endmodule

// File: tb/tb_hps_frame_scheduler.sv
// Randomized scoreboard bench for hps_frame_scheduler with a frame-level reference model.
module tb_hps_frame_scheduler;
  localparam int FL  = 1024;
  localparam int NP  = 32;
  localparam int FB  = 2;
  localparam int TMO = 4096;

  typedef struct packed {
    logic [5:0]  bin;
    logic [47:0] mag;
    logic        match;
  } exp_t;

  logic        clk = 1'b0, reset_n = 1'b0;
  logic [23:0] s_data = '0;
  logic        s_valid = 1'b0, s_last = 1'b0, s_ready;
  logic [23:0] h_data;
  logic        h_valid, h_rst;
  logic [47:0] p_data = '0, m_data = '0;
  logic        p_valid = 1'b0, p_ready, m_valid = 1'b0, m_ready;
  logic [5:0]  r_bin;
  logic [47:0] r_mag;
  logic        r_match, r_valid, r_ready = 1'b0;
  logic [15:0] frames_dropped;
  logic        err_short, err_timeout;

  hps_frame_scheduler #(.FRAME_LEN(FL), .NUM_PROD(NP), .FIRST_BIN(FB), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset_n(reset_n),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last),
    .h_data(h_data), .h_valid(h_valid), .h_rst(h_rst),
    .p_data(p_data), .p_valid(p_valid), .p_ready(p_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .r_bin(r_bin), .r_mag(r_mag), .r_match(r_match), .r_valid(r_valid), .r_ready(r_ready),
    .frames_dropped(frames_dropped), .err_short(err_short), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int hv_cnt = 0, es_cnt = 0, et_cnt = 0, hr_cnt = 0, res_cnt = 0, cyc = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  bit hold_rr = 1'b0;
  logic [47:0] prod_a [NP];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  initial forever begin
    @(posedge clk); #1;
    r_ready = hold_rr ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  // Monitor: event counters and the result scoreboard.
  always @(negedge clk) begin
    if (reset_n) begin
      if (h_valid) begin
        hv_cnt++;
        if (h_data !== s_data) chk("h_data", 64'(h_data), 64'(s_data));
      end
      if (err_short)   es_cnt++;
      if (err_timeout) et_cnt++;
      if (h_rst)       hr_cnt++;
      if (r_valid && r_ready) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL result_unexpected actual bin=%0d mag=%0h required none", r_bin, r_mag);
        end else begin
          mon_e = exp_q.pop_front();
          chk("r_bin",   64'(r_bin),   64'(mon_e.bin));
          chk("r_mag",   64'(r_mag),   64'(mon_e.mag));
          chk("r_match", 64'(r_match), 64'(mon_e.match));
          res_cnt++;
        end
      end
    end
  end

  // Reference: peak value of the frame, then the first beat holding it.
  function automatic logic [47:0] max_prod();
    logic [47:0] mx = '0;
    foreach (prod_a[i]) if (prod_a[i] > mx) mx = prod_a[i];
    return mx;
  endfunction

  function automatic exp_t model(input logic [47:0] mval);
    exp_t e;
    logic [47:0] mx = max_prod();
    int idx = NP;
    for (int i = NP - 1; i >= 0; i--) if (prod_a[i] == mx) idx = i;
    e.bin   = 6'(idx + FB);
    e.mag   = mx;
    e.match = (mx == mval);
    return e;
  endfunction

  task automatic fill(input int mode);
    foreach (prod_a[i])
      prod_a[i] = (mode == 0) ? 48'({$urandom, $urandom}) : 48'($urandom_range(0, 7));
  endtask

  task automatic beat(input logic last);
    s_valid = 1'b1; s_data = 24'($urandom); s_last = last;
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
    if ($urandom_range(0, 15) == 0) begin @(posedge clk); #1; end
  endtask

  task automatic send_beats(input int from, input int to, input int last_idx);
    for (int i = from; i <= to; i++) beat(i == last_idx);
  endtask

  task automatic hps_respond(input logic [47:0] mval, input bit give_max, input int m_at, input bit extra);
    for (int i = 0; i < NP; i++) begin
      p_valid = 1'b1; p_data = prod_a[i];
      m_valid = give_max && (i == m_at); m_data = mval;
      @(posedge clk); #1;
      p_valid = 1'b0; m_valid = 1'b0;
      if ($urandom_range(0, 7) == 0) begin @(posedge clk); #1; end
    end
    if (extra) begin p_valid = 1'b1; p_data = '1; @(posedge clk); #1; p_valid = 1'b0; end
    if (give_max && m_at >= NP) begin
      m_valid = 1'b1; m_data = mval; @(posedge clk); #1; m_valid = 1'b0;
    end
  endtask

  task automatic wait_results(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 20000) begin @(negedge clk); n++; end
    chk(name, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  task automatic run_frame(input exp_t e, input logic [47:0] mval, input int m_at, input bit extra);
    int hv0 = hv_cnt;
    exp_q.push_back(e);
    send_beats(0, FL - 1, FL - 1);
    chk("h_valid_count", 64'(hv_cnt - hv0), 64'(FL));
    hps_respond(mval, 1'b1, m_at, extra);
    wait_results("result_wait");
  endtask

  initial begin
    repeat (80000) @(posedge clk);
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_drop, hv0, es0, hr0, et0, c0, n;
    logic [47:0] mx, mval;
    exp_t e;

    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("rst_r_valid", 64'(r_valid), 64'd0);
    chk("rst_r_bin",   64'(r_bin),   64'd0);
    chk("rst_r_mag",   64'(r_mag),   64'd0);
    chk("rst_dropped", 64'(frames_dropped), 64'd0);
    chk("rst_err_short", 64'(err_short), 64'd0);
    chk("rst_err_tmo", 64'(err_timeout), 64'd0);
    chk("rst_h_valid", 64'(h_valid), 64'd0);
    chk("rst_m_ready", 64'(m_ready), 64'd0);
    chk("rst_h_rst",   64'(h_rst),   64'd1);
    chk("s_ready",     64'(s_ready), 64'd1);
    @(posedge clk); #1 reset_n = 1'b1;
    @(negedge clk);
    chk("p_ready", 64'(p_ready), 64'd1);
    chk("h_rst_released", 64'(h_rst), 64'd0);

    // A lone frame end arms the scheduler; it counts as a dropped frame.
    beat(1'b1);
    exp_drop = 1;
    @(negedge clk);
    chk("drop_prime", 64'(frames_dropped), 64'(exp_drop));

    // Peak at beat 7.
    foreach (prod_a[i]) prod_a[i] = 48'($urandom_range(0, 32'h1233));
    prod_a[7] = 48'h1234;
    e.bin = 6'd9; e.mag = 48'h1234; e.match = 1'b1;
    run_frame(e, 48'h1234, NP, 1'b0);

    // Tie at beats 3 and 20; max arrives with the last product.
    foreach (prod_a[i]) prod_a[i] = 48'($urandom_range(0, 32'h4f));
    prod_a[3] = 48'h50; prod_a[20] = 48'h50;
    e.bin = 6'd5; e.mag = 48'h50; e.match = 1'b1;
    run_frame(e, 48'h50, NP - 1, 1'b0);

    for (int k = 0; k < 6; k++) begin
      fill(k % 2);
      mx   = max_prod();
      mval = (k == 3) ? mx + 48'd1 : mx;
      if (k == 2) run_frame(model(mval), mval, NP, 1'b1);
      else        run_frame(model(mval), mval, $urandom_range(0, NP), 1'b0);
    end

    // Result held in REPORT while a whole frame arrives: that frame is dropped.
    hold_rr = 1'b1;
    fill(0); mval = max_prod();
    exp_q.push_back(model(mval));
    send_beats(0, FL - 1, FL - 1);
    hps_respond(mval, 1'b1, $urandom_range(0, NP), 1'b0);
    n = 0;
    while (!r_valid && n < 200) begin @(negedge clk); n++; end
    chk("report_reached", 64'(r_valid), 64'd1);
    hv0 = hv_cnt;
    send_beats(0, FL - 1, FL - 1);
    exp_drop++;
    @(negedge clk);
    chk("drop_in_report", 64'(frames_dropped), 64'(exp_drop));
    chk("report_held", 64'(r_valid), 64'd1);
    chk("dropped_not_fwd", 64'(hv_cnt - hv0), 64'd0);
    hold_rr = 1'b0;
    wait_results("held_result");
    fill(1); mval = max_prod();
    run_frame(model(mval), mval, $urandom_range(0, NP), 1'b0);

    // Short frame: 501 beats.
    hv0 = hv_cnt; es0 = es_cnt; hr0 = hr_cnt;
    send_beats(0, 500, 500);
    repeat (3) @(negedge clk);
    chk("short_err", 64'(es_cnt - es0), 64'd1);
    chk("short_h_rst", 64'(hr_cnt - hr0), 64'd1);
    chk("short_h_valid", 64'(hv_cnt - hv0), 64'd501);
    chk("short_idle", 64'(m_ready), 64'd0);
    repeat (50) @(negedge clk);
    fill(0); mval = max_prod();
    run_frame(model(mval), mval, $urandom_range(0, NP), 1'b0);

    // Missing max: timeout measured from the frame-end edge.
    et0 = et_cnt; hr0 = hr_cnt;
    fill(0);
    send_beats(0, FL - 1, FL - 1);
    c0 = cyc;
    hps_respond('0, 1'b0, 0, 1'b0);
    n = 0;
    while (!err_timeout && n < 6000) begin @(negedge clk); n++; end
    chk("timeout_latency", 64'(cyc - c0), 64'(TMO));
    repeat (2) @(negedge clk);
    chk("timeout_err", 64'(et_cnt - et0), 64'd1);
    chk("timeout_h_rst", 64'(hr_cnt - hr0), 64'd1);
    chk("timeout_idle", 64'(m_ready), 64'd0);

    // Reset 300 beats into a frame; the remainder must be discarded.
    hv0 = hv_cnt;
    send_beats(0, 299, -1);
    chk("pre_reset_fwd", 64'(hv_cnt - hv0), 64'd300);
    reset_n = 1'b0;
    repeat (3) @(posedge clk); #1;
    reset_n = 1'b1;
    hv0 = hv_cnt;
    send_beats(300, FL - 1, FL - 1);
    exp_drop = 1;
    @(negedge clk);
    chk("post_reset_discard", 64'(hv_cnt - hv0), 64'd0);
    chk("post_reset_drop", 64'(frames_dropped), 64'(exp_drop));
    fill(0); mval = max_prod();
    run_frame(model(mval), mval, $urandom_range(0, NP), 1'b0);

    repeat (10) @(negedge clk);
    chk("total_err_short", 64'(es_cnt), 64'd1);
    chk("total_err_tmo", 64'(et_cnt), 64'd1);
    chk("total_h_rst", 64'(hr_cnt), 64'd2);
    chk("total_results", 64'(res_cnt), 64'd12);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
